// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: read-side FSM states, command encodings and burst length
// used by the read/write engines and their downstream buffers.
package sdram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TRIG = 2'd1,
      ST_WAIT = 2'd2
   } rd_state_t;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_ACT   = 4'b0011;
   localparam logic [3:0] CMD_READ  = 4'b0101;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_PRE   = 4'b0010;
   localparam logic [3:0] CMD_REF   = 4'b0001;
   localparam logic [3:0] CMD_MRS   = 4'b0000;

   localparam int unsigned BURST_LEN = 4;

endpackage

// File: rtl/sdram_sync_fifo.sv
// Synchronous FIFO with registered head word; level is DEPTH when full, 0 when empty.
// Caller must not pop when empty nor push when full without a simultaneous pop.
module sdram_sync_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 32,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned LW    = AW + 1
) (
   input  logic              sysclk_100M,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [LW-1:0]     level
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     rd_ptr_inc;

   assign rd_ptr_inc = rd_ptr + 1'b1;
   assign full       = (level == LW'(DEPTH));
   assign empty      = (level == '0);

   always_ff @(posedge sysclk_100M) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge sysclk_100M) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         dout   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr_inc;
         if (push && !pop)      level <= level + 1'b1;
         else if (!push && pop) level <= level - 1'b1;
         // Head register: next stored word after a pop, or the incoming word when it becomes head.
         if (pop && level > LW'(1))
            dout <= mem[rd_ptr_inc];
         else if (push && (empty || (pop && level == LW'(1))))
            dout <= din;
      end
   end

endmodule

// File: rtl/sdram_rd_fifo.sv
// SDRAM read-data buffer: FIFO + read_trig request FSM, watchdog and sticky error flags.
// Optional statistics counters enabled by defining SDRAM_RD_FIFO_STAT_EN.
module sdram_rd_fifo
   import sdram_pkg::*;
#(
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned REQ_WORDS = 12,
   parameter int unsigned TRIG_HOLD = 4,
   parameter int unsigned TIMEOUT   = 1023,
   localparam int unsigned LVL_W    = $clog2(DEPTH) + 1
) (
   input  logic              sysclk_100M,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [DATA_W-1:0] sdram_dq_in,
   input  logic              data_vld,
   output logic              read_trig,
   output logic [DATA_W-1:0] rd_dout,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [LVL_W-1:0]  fifo_level,
   output logic              ovf_err,
   output logic              timeout_err
`ifdef SDRAM_RD_FIFO_STAT_EN
   ,
   output logic [31:0]       rx_word_cnt,
   output logic [15:0]       req_cnt
`endif
);

   localparam int unsigned HOLD_W = (TRIG_HOLD > 1) ? $clog2(TRIG_HOLD) : 1;
   localparam int unsigned WORD_W = $clog2(REQ_WORDS + 1);
   localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

   rd_state_t         state, state_nx;
   logic [HOLD_W-1:0] hold_cnt;
   logic [WORD_W-1:0] word_cnt;
   logic [WD_W-1:0]   wd_cnt;
   logic              full, empty, push, pop, ovf_hit;
   logic              words_done, wd_expire, start_ok;
   logic [LVL_W-1:0]  free_words;

   assign rd_valid   = !empty;
   assign pop        = rd_valid & rd_ready;
   assign push       = data_vld & (!full | pop);
   assign ovf_hit    = data_vld & full & !pop;
   assign free_words = LVL_W'(DEPTH) - fifo_level;
   assign start_ok   = enable && (free_words >= LVL_W'(REQ_WORDS));

   sdram_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .sysclk_100M (sysclk_100M),
      .rst_n       (rst_n),
      .push        (push),
      .pop         (pop),
      .din         (sdram_dq_in),
      .dout        (rd_dout),
      .full        (full),
      .empty       (empty),
      .level       (fifo_level)
   );

   always_comb begin
      state_nx   = state;
      words_done = (data_vld && word_cnt >= WORD_W'(REQ_WORDS - 1)) ||
                   (word_cnt >= WORD_W'(REQ_WORDS));
      wd_expire  = (state == ST_WAIT) && !data_vld && (wd_cnt == WD_W'(TIMEOUT - 1));
      case (state)
         ST_IDLE: if (start_ok) state_nx = ST_TRIG;
         ST_TRIG: if (hold_cnt == HOLD_W'(TRIG_HOLD - 1)) state_nx = ST_WAIT;
         ST_WAIT: if (words_done || wd_expire) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge sysclk_100M) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         read_trig   <= 1'b0;
         hold_cnt    <= '0;
         word_cnt    <= '0;
         wd_cnt      <= '0;
         ovf_err     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state     <= state_nx;
         read_trig <= (state_nx == ST_TRIG);
         hold_cnt  <= (state == ST_TRIG && state_nx == ST_TRIG) ? hold_cnt + 1'b1 : '0;
         // Words seen while idle are buffered but never credited to the next group.
         if (state == ST_IDLE)
            word_cnt <= '0;
         else if (data_vld && word_cnt < WORD_W'(REQ_WORDS))
            word_cnt <= word_cnt + 1'b1;
         wd_cnt <= (state == ST_WAIT && !data_vld) ? wd_cnt + 1'b1 : '0;
         if (ovf_hit)   ovf_err     <= 1'b1;
         if (wd_expire) timeout_err <= 1'b1;
      end
   end

`ifdef SDRAM_RD_FIFO_STAT_EN
   always_ff @(posedge sysclk_100M) begin
      if (!rst_n) begin
         rx_word_cnt <= '0;
         req_cnt     <= '0;
      end else begin
         if (data_vld) rx_word_cnt <= rx_word_cnt + 1'b1;
         if (state == ST_IDLE && state_nx == ST_TRIG) req_cnt <= req_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sdram_rd_fifo.sv
// Directed self-checking bench for sdram_rd_fifo (default build, DEPTH 32, 12-word groups).
module tb_sdram_rd_fifo;

   logic        sysclk_100M = 1'b0;
   logic        rst_n       = 1'b0;
   logic        enable      = 1'b0;
   logic [15:0] sdram_dq_in = '0;
   logic        data_vld    = 1'b0;
   logic        rd_ready    = 1'b0;
   logic        read_trig;
   logic [15:0] rd_dout;
   logic        rd_valid;
   logic [5:0]  fifo_level;
   logic        ovf_err;
   logic        timeout_err;
`ifdef SDRAM_RD_FIFO_STAT_EN
   logic [31:0] rx_word_cnt;
   logic [15:0] req_cnt;
`endif

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   sdram_rd_fifo #(
      .DATA_W    (16),
      .DEPTH     (32),
      .REQ_WORDS (12),
      .TRIG_HOLD (4),
      .TIMEOUT   (1023)
   ) dut (
      .sysclk_100M (sysclk_100M),
      .rst_n       (rst_n),
      .enable      (enable),
      .sdram_dq_in (sdram_dq_in),
      .data_vld    (data_vld),
      .read_trig   (read_trig),
      .rd_dout     (rd_dout),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .fifo_level  (fifo_level),
      .ovf_err     (ovf_err),
      .timeout_err (timeout_err)
`ifdef SDRAM_RD_FIFO_STAT_EN
      ,
      .rx_word_cnt (rx_word_cnt),
      .req_cnt     (req_cnt)
`endif
   );

   always #5 sysclk_100M = ~sysclk_100M;

   task automatic tick();
      @(posedge sysclk_100M);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic wait_trig(input logic want, input int limit);
      int n;
      n = 0;
      while (read_trig !== want && n < limit) begin
         tick();
         n++;
      end
      if (read_trig !== want) chk("wait_read_trig", {31'd0, read_trig}, {31'd0, want});
   endtask

   task automatic send_words(input logic [15:0] base, input int cnt);
      for (int i = 0; i < cnt; i++) begin
         data_vld    = 1'b1;
         sdram_dq_in = base + 16'(i);
         tick();
      end
      data_vld = 1'b0;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_level"},   32'(fifo_level),  32'd0);
      chk({tag, "_valid"},   32'(rd_valid),    32'd0);
      chk({tag, "_trig"},    32'(read_trig),   32'd0);
      chk({tag, "_ovf"},     32'(ovf_err),     32'd0);
      chk({tag, "_timeout"}, 32'(timeout_err), 32'd0);
      chk({tag, "_dout"},    32'(rd_dout),     32'd0);
   endtask

   initial begin
      int hi, t_rise, saw, cnt;
      logic [15:0] exp_q[$];

      // Reset state
      tick();
      tick();
      chk_cleared("rst");

      // First group: trigger pulse width, 12 words, second trigger spacing
      rst_n  = 1'b1;
      enable = 1'b1;
      chk("trig_before", 32'(read_trig), 32'd0);
      tick();
      chk("trig_rise", 32'(read_trig), 32'd1);
      t_rise = cyc;
      hi = 1;
      tick();
      while (read_trig === 1'b1 && hi < 20) begin
         hi++;
         tick();
      end
      chk("trig_width", 32'(hi), 32'd4);
      send_words(16'h0001, 12);
      chk("g1_level", 32'(fifo_level), 32'd12);
      chk("g1_valid", 32'(rd_valid),   32'd1);
      chk("g1_head",  32'(rd_dout),    32'h0001);
      chk("g1_trig",  32'(read_trig),  32'd0);
      tick();
      chk("g2_trig",  32'(read_trig),  32'd1);
      chk("trig_gap", 32'(cyc - t_rise), 32'd17);

      // Consumer stalled: second group fills to 24, then no room for a third
      wait_trig(1'b0, 10);
      send_words(16'h0101, 12);
      chk("g2_level", 32'(fifo_level), 32'd24);
      saw = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (read_trig === 1'b1) saw = 1;
      end
      chk("no_trig_free8", 32'(saw),        32'd0);
      chk("hold_level24",  32'(fifo_level), 32'd24);
      chk("no_ovf24",      32'(ovf_err),    32'd0);

      // Fill to full while idle, then push+pop at full and a dropped word
      enable = 1'b0;
      send_words(16'h0201, 8);
      chk("full_level", 32'(fifo_level), 32'd32);
      chk("full_ovf0",  32'(ovf_err),    32'd0);
      chk("full_head",  32'(rd_dout),    32'h0001);
      data_vld    = 1'b1;
      sdram_dq_in = 16'hBEEF;
      rd_ready    = 1'b1;
      tick();
      data_vld = 1'b0;
      rd_ready = 1'b0;
      chk("pp_full_level", 32'(fifo_level), 32'd32);
      chk("pp_full_ovf",   32'(ovf_err),    32'd0);
      chk("pp_full_head",  32'(rd_dout),    32'h0002);
      data_vld    = 1'b1;
      sdram_dq_in = 16'hDEAD;
      tick();
      data_vld = 1'b0;
      chk("drop_level", 32'(fifo_level), 32'd32);
      chk("drop_ovf",   32'(ovf_err),    32'd1);
      chk("drop_head",  32'(rd_dout),    32'h0002);

      // Back-to-back drain: order must skip the dropped word and end with 0xBEEF
      for (int i = 2; i <= 12; i++) exp_q.push_back(16'(i));
      for (int i = 0; i < 12; i++)  exp_q.push_back(16'h0101 + 16'(i));
      for (int i = 0; i < 8; i++)   exp_q.push_back(16'h0201 + 16'(i));
      exp_q.push_back(16'hBEEF);
      rd_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         chk("drain_word", 32'(rd_dout), 32'(exp_q[i]));
         tick();
      end
      rd_ready = 1'b0;
      chk("drain_level", 32'(fifo_level), 32'd0);
      chk("drain_valid", 32'(rd_valid),   32'd0);

      // Watchdog: trig with no data, WAIT lasts TIMEOUT cycles then flags and idles
      rst_n = 1'b0;
      tick();
      chk("rst2_ovf", 32'(ovf_err), 32'd0);
      rst_n  = 1'b1;
      enable = 1'b1;
      wait_trig(1'b1, 5);
      wait_trig(1'b0, 10);
      cnt = 0;
      while (timeout_err !== 1'b1 && cnt < 1200) begin
         tick();
         cnt++;
      end
      chk("timeout_cycles", 32'(cnt),         32'd1023);
      chk("timeout_err",    32'(timeout_err), 32'd1);
      chk("timeout_trig0",  32'(read_trig),   32'd0);
      tick();
      chk("timeout_retrig", 32'(read_trig),   32'd1);
      enable = 1'b0;

      // Push+pop every cycle at level 1
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      send_words(16'hA000, 1);
      chk("pp1_level0", 32'(fifo_level), 32'd1);
      chk("pp1_head0",  32'(rd_dout),    32'hA000);
      for (int i = 1; i <= 6; i++) begin
         data_vld    = 1'b1;
         sdram_dq_in = 16'hA000 + 16'(i);
         rd_ready    = 1'b1;
         tick();
         chk("pp1_level", 32'(fifo_level), 32'd1);
         chk("pp1_head",  32'(rd_dout),    32'hA000 + 32'(i));
      end
      data_vld = 1'b0;
      rd_ready = 1'b0;

      // Reset in the middle of a group
      rst_n = 1'b0;
      tick();
      rst_n  = 1'b1;
      enable = 1'b1;
      wait_trig(1'b1, 5);
      wait_trig(1'b0, 10);
      send_words(16'h5000, 5);
      chk("mid_level", 32'(fifo_level), 32'd5);
      rst_n = 1'b0;
      tick();
      chk_cleared("mid_rst");
      rst_n  = 1'b1;
      enable = 1'b0;
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
